// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag indices, slot-state encoding and PADDSB helper for the ALU arbiter
package alu_pkg;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_PADDSB = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_NOR    = 3'd4;
    localparam logic [2:0] ALU_SLL    = 3'd5;
    localparam logic [2:0] ALU_SRL    = 3'd6;
    localparam logic [2:0] ALU_SRA    = 3'd7;

    localparam int FLG_OV  = 2;
    localparam int FLG_ZR  = 1;
    localparam int FLG_NEG = 0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Signed 4-bit add that clamps to +7 / -8 instead of wrapping.
    function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] s;
        s = a + b;
        if ((a[3] == b[3]) && (s[3] != a[3]))
            sat_add4 = a[3] ? 4'h8 : 4'h7;
        else
            sat_add4 = s;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester request bus plus response slot and flag register
interface alu_arbiter_if #(parameter int TAG_W = 2);

    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [15:0]      req0_a;
    logic [15:0]      req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [15:0]      req1_a;
    logic [15:0]      req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [15:0]      rsp_result;
    logic [2:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;

    logic [2:0]       flags_q;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_tag, flags_q
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_tag, flags_q
    );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational 16-bit ALU producing result and {ov, zr, neg}
module alu
    import alu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic [2:0]  flags
);

    logic ov;

    always_comb begin
        result = '0;
        ov     = 1'b0;
        case (op)
            ALU_ADD: begin
                result = a + b;
                ov     = (a[15] == b[15]) && (result[15] != a[15]);
            end
            ALU_PADDSB: result = {sat_add4(a[15:12], b[15:12]), sat_add4(a[11:8], b[11:8]),
                                  sat_add4(a[7:4], b[7:4]), sat_add4(a[3:0], b[3:0])};
            ALU_SUB: begin
                result = a - b;
                ov     = (a[15] != b[15]) && (result[15] != a[15]);
            end
            ALU_AND: result = a & b;
            ALU_NOR: result = ~(a | b);
            ALU_SLL: result = a << b[3:0];
            ALU_SRL: result = a >> b[3:0];
            ALU_SRA: result = 16'($signed(a) >>> b[3:0]);
            default: result = '0;
        endcase
    end

    // Overflow is only meaningful for the two's-complement add/subtract paths.
    always_comb begin
        flags          = '0;
        flags[FLG_OV]  = ov;
        flags[FLG_ZR]  = (result == 16'h0000);
        flags[FLG_NEG] = result[15];
    end

endmodule

// File: rtl/alu_arb_gnt.sv
// rtl/alu_arb_gnt.sv - two-requester grant; ALU_ARB_RR_EN selects round-robin vs fixed tie-break
module alu_arb_gnt (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic can_issue,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_gnt_q;
    logic last_gnt_d;

    always_comb begin
        gnt_valid = valid0 | valid1;
        gnt_id    = 1'b0;
        if (valid0 && valid1) begin
`ifdef ALU_ARB_RR_EN
            gnt_id = ~last_gnt_q;
`else
            gnt_id = 1'b0;
`endif
        end else begin
            gnt_id = valid1;
        end
    end

    // Tracked in both builds so the tie-break can be switched without other changes.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_valid && can_issue)
            last_gnt_d = gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt_q <= 1'b1;
        else
            last_gnt_q <= last_gnt_d;
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters with a registered response slot; build option ALU_ARB_RR_EN
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   bus
);

    slot_state_e      state_q, state_d;
    logic             rsp_id_q, rsp_id_d;
    logic [15:0]      rsp_result_q, rsp_result_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic [2:0]       flags_q, flags_d;

    logic             can_issue;
    logic             gnt_valid;
    logic             gnt_id;
    logic             accept;
    logic             retire;
    logic [2:0]       alu_op;
    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic [TAG_W-1:0] alu_tag;
    logic [15:0]      alu_result;
    logic [2:0]       alu_flags;

    assign can_issue = (state_q == SLOT_EMPTY) || bus.rsp_ready;
    assign retire    = (state_q == SLOT_FULL) && bus.rsp_ready;
    assign accept    = rst_n && gnt_valid && can_issue;

    alu_arb_gnt u_gnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .can_issue (can_issue),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign alu_op  = gnt_id ? bus.req1_op  : bus.req0_op;
    assign alu_a   = gnt_id ? bus.req1_a   : bus.req0_a;
    assign alu_b   = gnt_id ? bus.req1_b   : bus.req0_b;
    assign alu_tag = gnt_id ? bus.req1_tag : bus.req0_tag;

    alu u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_op_d     = rsp_op_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (accept) state_d = SLOT_FULL;
            end
            SLOT_FULL: begin
                if (accept)      state_d = SLOT_FULL;
                else if (retire) state_d = SLOT_EMPTY;
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (accept) begin
            rsp_id_d     = gnt_id;
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_tag_d    = alu_tag;
            rsp_op_d     = alu_op;
        end
    end

    // Architectural flags follow the op being retired, not the one being accepted.
    always_comb begin
        flags_d = flags_q;
        if (retire) begin
            case (rsp_op_q)
                ALU_ADD, ALU_SUB: flags_d = rsp_flags_q;
                ALU_PADDSB:       flags_d = flags_q;
                default:          flags_d[FLG_ZR] = rsp_flags_q[FLG_ZR];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SLOT_EMPTY;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
            rsp_op_q     <= ALU_ADD;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_op_q     <= rsp_op_d;
            flags_q      <= flags_d;
        end
    end

    assign bus.req0_ready = accept && !gnt_id;
    assign bus.req1_ready = accept &&  gnt_id;
    assign bus.rsp_valid  = (state_q == SLOT_FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.flags_q    = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with hand-computed directed vectors
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic        id;
        logic [15:0] result;
        logic [2:0]  flags;
        logic [1:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    alu_arbiter_if #(.TAG_W(2)) bus ();

    alu_arbiter #(.TAG_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every retiring response is compared against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_result), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id",     32'(bus.rsp_id),     32'(e.id));
                    check("rsp_result", 32'(bus.rsp_result), 32'(e.result));
                    check("rsp_flags",  32'(bus.rsp_flags),  32'(e.flags));
                    check("rsp_tag",    32'(bus.rsp_tag),    32'(e.tag));
                end
            end
        end
    end

    task automatic drive(input logic id, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [1:0] tag);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] tag, input logic [15:0] er, input logic [2:0] ef);
        int n;
        logic rdy;
        drive(id, 1'b1, op, a, b, tag);
        n = 0;
        @(negedge clk);
        rdy = id ? bus.req1_ready : bus.req0_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = id ? bus.req1_ready : bus.req0_ready;
            n++;
        end
        check("accept_timeout", 32'(rdy), 32'd1);
        if (rdy) exp_q.push_back('{id: id, result: er, flags: ef, tag: tag});
        @(posedge clk); #1;
        drive(id, 1'b0, op, a, b, tag);
    endtask

    task automatic send_retire(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [1:0] tag, input logic [15:0] er, input logic [2:0] ef,
                               input logic [2:0] exp_flags_q, input string name);
        send(id, op, a, b, tag, er, ef);
        @(posedge clk); #1;
        check(name, 32'(bus.flags_q), 32'(exp_flags_q));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_id;
        drive(1'b0, 1'b1, ALU_ADD, 16'h0001, 16'h0001, 2'd0);
        drive(1'b1, 1'b1, ALU_ADD, 16'h0001, 16'h0001, 2'd0);
        bus.rsp_ready = 1'b1;
        #12;
        check("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("rst_rsp_id",     32'(bus.rsp_id),     32'd0);
        check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("rst_rsp_flags",  32'(bus.rsp_flags),  32'd0);
        check("rst_rsp_tag",    32'(bus.rsp_tag),    32'd0);
        check("rst_flags_q",    32'(bus.flags_q),    32'd0);
        check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        drive(1'b0, 1'b0, ALU_ADD, 16'h0, 16'h0, 2'd0);
        drive(1'b1, 1'b0, ALU_ADD, 16'h0, 16'h0, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AND with zero result, latency and delayed flag update
        send(1'b0, ALU_AND, 16'h00F0, 16'h0F00, 2'd1, 16'h0000, 3'b010);
        check("and_rsp_valid_next", 32'(bus.rsp_valid), 32'd1);
        check("and_flags_q_before", 32'(bus.flags_q), 32'd0);
        @(posedge clk); #1;
        check("and_flags_q", 32'(bus.flags_q), 32'b010);

        send_retire(1'b0, ALU_ADD,    16'h0003, 16'h0004, 2'd2, 16'h0007, 3'b000, 3'b000, "add_flags_q");
        send_retire(1'b0, ALU_PADDSB, 16'h78F1, 16'h18FF, 2'd3, 16'h78E0, 3'b000, 3'b000, "paddsb_flags_q");
        send_retire(1'b0, ALU_SLL,    16'h0000, 16'h0003, 2'd0, 16'h0000, 3'b010, 3'b010, "sll_flags_q");
        send_retire(1'b0, ALU_SRA,    16'h8000, 16'h0004, 2'd1, 16'hF800, 3'b001, 3'b000, "sra_flags_q");
        send_retire(1'b1, ALU_SRL,    16'h8000, 16'h000F, 2'd2, 16'h0001, 3'b000, 3'b000, "srl_flags_q");
        send_retire(1'b0, ALU_SUB,    16'h0005, 16'h0007, 2'd3, 16'hFFFE, 3'b001, 3'b001, "sub_neg_flags_q");
        send_retire(1'b1, ALU_SUB,    16'h8000, 16'h0001, 2'd0, 16'h7FFF, 3'b100, 3'b100, "sub_ov_flags_q");
        send_retire(1'b0, ALU_NOR,    16'hFFFF, 16'h0000, 2'd1, 16'h0000, 3'b010, 3'b110, "nor_flags_q");

        // Stall: slot full, consumer not ready, both requesters waiting
        bus.rsp_ready = 1'b0;
        send(1'b0, ALU_SUB, 16'h0005, 16'h0005, 2'd1, 16'h0000, 3'b010);
        drive(1'b0, 1'b1, ALU_AND, 16'hFFFF, 16'h1234, 2'd2);
        drive(1'b1, 1'b1, ALU_NOR, 16'hFFFF, 16'h0000, 2'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_rsp_valid",  32'(bus.rsp_valid),  32'd1);
            check("stall_rsp_result", 32'(bus.rsp_result), 32'h0000);
            check("stall_rsp_flags",  32'(bus.rsp_flags),  32'b010);
            check("stall_rsp_id",     32'(bus.rsp_id),     32'd0);
            check("stall_rsp_tag",    32'(bus.rsp_tag),    32'd1);
            check("stall_req0_ready", 32'(bus.req0_ready), 32'd0);
            check("stall_req1_ready", 32'(bus.req1_ready), 32'd0);
            check("stall_flags_q",    32'(bus.flags_q),    32'b110);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
`ifdef ALU_ARB_RR_EN
        exp_id = 1'b1;
`else
        exp_id = 1'b0;
`endif
        check("unstall_req0_ready", 32'(bus.req0_ready), 32'(!exp_id));
        check("unstall_req1_ready", 32'(bus.req1_ready), 32'(exp_id));
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("unstall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("unstall_rsp_id",    32'(bus.rsp_id),    32'(exp_id));
        check("unstall_flags_q",   32'(bus.flags_q),   32'b010);

        // Asynchronous reset with a response in flight; it must be discarded
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("arst_flags_q",    32'(bus.flags_q),    32'd0);
        check("arst_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("arst_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("arst_req1_ready", 32'(bus.req1_ready), 32'd0);
        exp_q.delete();
        drive(1'b0, 1'b1, ALU_ADD, 16'h0010, 16'h0001, 2'd2);
        drive(1'b1, 1'b1, ALU_ADD, 16'h7FFF, 16'h0001, 2'd3);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Both valid every cycle: grant sequence and one op per cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef ALU_ARB_RR_EN
            exp_id = i[0];
`else
            exp_id = 1'b0;
`endif
            check("tie_req0_ready", 32'(bus.req0_ready), 32'(!exp_id));
            check("tie_req1_ready", 32'(bus.req1_ready), 32'(exp_id));
            if (exp_id)
                exp_q.push_back('{id: 1'b1, result: 16'h8000, flags: 3'b101, tag: 2'd3});
            else
                exp_q.push_back('{id: 1'b0, result: 16'h0011, flags: 3'b000, tag: 2'd2});
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, ALU_ADD, 16'h0, 16'h0, 2'd0);
        drive(1'b1, 1'b0, ALU_ADD, 16'h0, 16'h0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_rsp_valid",   32'(bus.rsp_valid), 32'd0);
`ifdef ALU_ARB_RR_EN
        check("tie_final_flags_q", 32'(bus.flags_q), 32'b101);
`else
        check("tie_final_flags_q", 32'(bus.flags_q), 32'b000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit ALU datapath (ADD, PADDSB, SUB, AND, NOR, SLL, SRL, SRA) between two requesters, e.g. the execute stage and the address-generation unit. Valid/ready on both sides, round-robin grant, and a one-entry registered response slot carrying result, flags and requester id. It also holds the architectural flag register (ov, zr, neg), updated only when a response retires.

## Interface
- TAG_W, default 2: width of the opaque per-request tag echoed on the response.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle; may depend on valid.
- req0_op / req1_op  in  3  ALU opcode, 0..7 = ADD, PADDSB, SUB, AND, NOR, SLL, SRL, SRA.
- req0_a / req1_a  in  16  operand src0.
- req0_b / req1_b  in  16  operand src1; shifts use bits [3:0].
- req0_tag / req1_tag  in  TAG_W  tag.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  16  ALU result.
- rsp_flags  out  3  {ov, zr, neg} as produced by the ALU for this op.
- rsp_tag  out  TAG_W  echoed tag.
- flags_q  out  3  architectural {ov, zr, neg} register.

## Operation
- Two-state slot FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_issue = EMPTY or (FULL and rsp_ready).
- Grant is combinational:
  - With a single valid requester and can_issue, that requester is granted.
  - With both valid, the requester opposite last_gnt is granted.
- reqN_ready = can_issue and grant to N; at most one ready per cycle.
- On accept, the ALU is driven with the granted op and operands. Result, flags, id and tag are registered into the slot, which becomes or stays FULL. last_gnt is set to the granted id.
- FULL and rsp_ready and no accept: the slot goes to EMPTY.
- FULL and not rsp_ready: all rsp_* outputs are held bit-stable and both readies are 0.
- Flag register update occurs on the retire cycle only (rsp_valid and rsp_ready):
  - ADD, SUB: write ov, zr, neg.
  - AND, NOR, SLL, SRL, SRA: write zr only; ov and neg are held.
  - PADDSB: flags_q unchanged.
- Opcodes are all 3-bit, so no illegal encodings exist.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_tag=0, flags_q=0, last_gnt=1 (so req0 wins the first tie). Both readies are 0 while rst_n=0.

## Timing
- Latency: accept in cycle N gives rsp_valid=1 in cycle N+1.
- Throughput: 1 op/cycle while rsp_ready=1 (retire and accept occur in the same cycle).
- flags_q reflects a retired op one cycle after the retire edge.
- Reset mid-operation: an in-flight response is discarded, rsp_valid falls immediately (asynchronous), and nothing retires.
- No combinational path from rsp_ready to rsp_* data.

## Configuration
- ALU_ARB_RR_EN defined: round-robin tie-break as above.
- ALU_ARB_RR_EN undefined: fixed priority, req0 always wins ties. last_gnt is still maintained but ignored. req1 can starve; this is acceptable for single-master builds.

## Structure
- Package alu_pkg holds:
  - opcode localparams ALU_ADD..ALU_SRA (3'd0..3'd7);
  - flag index constants FLG_OV=2, FLG_ZR=1, FLG_NEG=0;
  - the slot-state encoding.
- Sub-module alu_arb_gnt: two-requester grant logic, including the ALU_ARB_RR_EN selection and last_gnt.
- The existing alu module is instantiated once inside alu_arbiter.

## Test plan
- req0 AND a=0x00F0 b=0x0F00 tag=1, rsp_ready=1:
  - next cycle rsp_valid=1, rsp_result=0x0000, rsp_flags=3'b010, rsp_id=0, rsp_tag=1;
  - flags_q=3'b010 one cycle later.
- Both valid every cycle, ADD ops, rsp_ready=1:
  - with RR_EN, rsp_id sequence 0,1,0,1 at 1/cycle;
  - without RR_EN, 0,0,0,0 and req1_ready never asserted.
- Slot FULL, rsp_ready=0 for 3 cycles with both requesters valid: rsp_* stable, both readies 0, flags_q unchanged. Raising rsp_ready retires and accepts in the same cycle.
- Flag update rules, starting from flags_q=3'b010:
  - retire ADD 0x0003+0x0004: rsp_result=0x0007, flags_q=3'b000;
  - then retire PADDSB: flags_q stays 3'b000;
  - then retire SLL a=0x0000 b=0x0003: flags_q=3'b010.
- Assert rst_n=0 while rsp_valid=1: rsp_valid and flags_q go to 0 without a clock edge. After release, with both requesters valid, the first grant goes to req0.
